// File: rtl/booth_shift_unit.sv
// Multi-mode, multi-cycle shift register for the Booth multiplier datapath.
// A start/busy/done sequencer shifts the register by a programmed amount,
// up to STEP bits per clock, and tracks the Booth Q(-1) bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; load and start accepted
// ST_SHIFT | shifting min(rem, STEP) bits per edge; load/start ignored
// ST_DONE  | one-cycle completion pulse; load and start accepted
module booth_shift_unit #(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int CW   = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [N-1:0]    data_in,
    input  logic [STEP-1:0] serial_in,
    input  logic [1:0]      mode,
    input  logic            start,
    input  logic [CW-1:0]   amount,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    data_out,
    output logic            q_m1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          qm1_q, qm1_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [1:0]    mode_q, mode_d;

    logic [CW-1:0] k;
    logic [N-1:0]  shifted;
    logic          shifted_qm1;

    // Bits moved this edge: whatever is left, capped at the per-cycle width.
    always_comb begin
        k = (rem_q < STEP_C) ? rem_q : STEP_C;
    end

    // Datapath: apply k single-bit steps; serial_in[0] goes in first so that
    // serial_in[k-1] ends up in the MSB, and the last bit out of the LSB
    // (original bit k-1) becomes Q(-1).
    always_comb begin
        shifted     = data_q;
        shifted_qm1 = qm1_q;
        for (int i = 0; i < STEP; i++) begin
            if (CW'(i) < k) begin
                case (mode_q)
                    2'b00: begin
                        shifted_qm1 = shifted[0];
                        shifted     = {shifted[N-1], shifted[N-1:1]};
                    end
                    2'b01: begin
                        shifted_qm1 = shifted[0];
                        shifted     = {serial_in[i], shifted[N-1:1]};
                    end
                    2'b10: begin
                        shifted     = {shifted[N-2:0], 1'b0};
                    end
                    default: begin
                        shifted_qm1 = shifted[0];
                        shifted     = {shifted[0], shifted[N-1:1]};
                    end
                endcase
            end
        end
    end

    // Sequencer and register next-state; clear beats load beats start.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        qm1_d   = qm1_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        if (clear) begin
            data_d  = '0;
            qm1_d   = 1'b0;
            rem_d   = '0;
            state_d = ST_IDLE;
        end else if (load && state_q != ST_SHIFT) begin
            data_d  = data_in;
            qm1_d   = 1'b0;
            state_d = ST_IDLE;
        end else if (start && state_q != ST_SHIFT) begin
            mode_d  = mode;
            rem_d   = amount;
            state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
        end else if (state_q == ST_SHIFT) begin
            data_d  = shifted;
            qm1_d   = shifted_qm1;
            rem_d   = rem_q - k;
            state_d = (rem_q == k) ? ST_DONE : ST_SHIFT;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            qm1_q   <= 1'b0;
            rem_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            qm1_q   <= qm1_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign data_out = data_q;
    assign q_m1     = qm1_q;

endmodule

// File: doc/booth_shift_unit.md
Name: booth_shift_unit

Overview:
- Parametrised, multi-mode, multi-cycle shift register for the Booth multiplier datapath. It generalises the single-bit arithmetic-right accumulator shifter.
- Width is set by N. Bits shifted per cycle is set by STEP: 1 for radix-2 Booth, 2 for radix-4.
- A start/busy/done sequencer shifts the register by a programmed amount.
- It tracks the Booth Q(-1) bit and supports four shift modes.

Parameters:
- N, 8, register width in bits (N >= 4).
- STEP, 1, maximum bits shifted per cycle (1 or 2).
- CW, $clog2(N)+1, width of the amount port.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear.
- load  in  1  synchronous parallel load of data_in.
- data_in  in  N  parallel load value.
- serial_in  in  STEP  fill bits for mode 01; sampled live on each shift edge.
- mode  in  2  00 arithmetic right, 01 right with serial_in fill, 10 logical left, 11 rotate right.
- start  in  1  begin a shift operation; mode and amount are latched on this edge.
- amount  in  CW  total bit positions to shift (0..2^CW-1).
- busy  out  1  high while in SHIFT state.
- done  out  1  one-cycle pulse when the operation completes.
- data_out  out  N  register contents.
- q_m1  out  1  bit most recently shifted out of the LSB (Booth Q-1).

Behaviour:
- Reset (rst_n=0, async): data_out=0, q_m1=0, busy=0, done=0, state=IDLE, remaining count=0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1, busy=0, lasts exactly one cycle, then goes to IDLE.
- Priority on each edge: clear > load > start.
  - clear in any state: data_out=0, q_m1=0, state=IDLE, no done pulse (aborts an operation in progress).
  - load accepted only in IDLE or DONE: data_out=data_in, q_m1=0, next state IDLE. Ignored in SHIFT.
  - start accepted only in IDLE or DONE, and only when load and clear are low. It latches mode and amount into rem.
    - rem=0: next state is DONE, register unchanged.
    - Otherwise: next state is SHIFT.
  - start in SHIFT is ignored.
- SHIFT edge:
  - k = min(rem, STEP); shift data_out by k in the latched mode; rem -= k.
  - If the new rem is 0, next state is DONE; otherwise stay in SHIFT.
- Latency: done is high during the cycle following the final shift edge. Start sampled at edge t gives done high in the cycle after edge t+ceil(amount/STEP).
- Back-to-back: start sampled in DONE begins the next operation with no idle cycle.
- Per-mode k-bit shift:
  - 00: sign-fill the top k bits with data_out[N-1].
  - 01: the top k bits become serial_in[k-1:0] (serial_in[k-1] lands in the MSB).
  - 10: shift left, zero-fill the bottom k bits.
  - 11: rotate right by k.
- q_m1 update:
  - Modes 00, 01, 11: q_m1 takes the highest of the k bits leaving the LSB end, i.e. data_out[k-1] before the shift.
  - Mode 10: q_m1 holds its value.
- amount >= N is legal and shifts the full count:
  - mode 00 saturates to all sign bits;
  - mode 10 goes to zero;
  - mode 11 wraps modulo N in effect.
- mode, amount and data_in are ignored except on the edges where they are accepted.

Test Plan:
- N=8, STEP=1: load 0x96; start, mode=00, amount=3 -> busy for 3 cycles; data_out 0xCB, 0xE5, 0xF2; q_m1=1; done pulses once on the 4th cycle after start.
- N=16, STEP=2: load 0x8001; start, mode=01, amount=3, serial_in=2'b10 held -> data_out 0xA000 with q_m1=0 after the first shift, then 0x5000 with q_m1=0; done 3 cycles after start.
- N=8, STEP=1, rotate/left: load 0x81; mode=11, amount=9 -> data_out 0xC0, q_m1=1. Then load 0x81; mode=10, amount=1 -> data_out 0x02, q_m1 unchanged at 0.
- amount=0 and back-to-back: start with amount=0 -> done high the next cycle, data_out unchanged. Assert start during that DONE cycle with mode=00, amount=1 -> shift happens with no IDLE gap.
- Abort and ignores: during SHIFT, pulse load (ignored, data continues shifting) and start (ignored). Then pulse clear -> next cycle data_out=0, q_m1=0, busy=0, no done pulse.
- Async reset mid-SHIFT: drop rst_n between clock edges -> data_out, q_m1, busy and done read 0 immediately, with no clock edge. Release rst_n -> IDLE, and a new start works normally.
